// File: rtl/ovc_state_tracker.sv
// Output-VC state tracker: per-OVC IDLE/ACTIVE/DRAIN state plus a downstream
// credit counter. Drives VC-allocator eligibility and credit-available flags,
// and raises a sticky error on any protocol violation.
module ovc_state_tracker #(
  parameter int num_ports     = 5,
  parameter int max_vc_number = 20,
  parameter int buffer_size   = 4,
  localparam int vc_idx_width = $clog2(max_vc_number),
  localparam int cred_width   = $clog2(buffer_size + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [num_ports*max_vc_number-1:0]   gnt_op_ovc,
  input  logic [num_ports-1:0]                 flit_valid_op,
  input  logic [num_ports*vc_idx_width-1:0]    flit_ovc_op,
  input  logic [num_ports-1:0]                 flit_tail_op,
  input  logic [num_ports-1:0]                 credit_valid_op,
  input  logic [num_ports*vc_idx_width-1:0]    credit_ovc_op,
  output logic [num_ports*max_vc_number-1:0]   elig_op_ovc,
  output logic [num_ports*max_vc_number-1:0]   cred_avail_op_ovc,
  output logic                                 error
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } ovc_state_e;

  localparam logic [cred_width-1:0] CRED_FULL = cred_width'(buffer_size);
  localparam logic [cred_width-1:0] CRED_ONE  = cred_width'(1);

  logic [num_ports-1:0]               flit_idx_err;
  logic [num_ports-1:0]               cred_idx_err;
  logic [num_ports*max_vc_number-1:0] ovc_err_vec;
  logic                               error_q, error_d;

  genvar gi, gj;
  generate
    for (gi = 0; gi < num_ports; gi++) begin : g_port
      logic [vc_idx_width-1:0] flit_idx;
      logic [vc_idx_width-1:0] cred_idx;

      assign flit_idx = flit_ovc_op[gi*vc_idx_width +: vc_idx_width];
      assign cred_idx = credit_ovc_op[gi*vc_idx_width +: vc_idx_width];

      // An index past the last OVC is reported and then matches no OVC below.
      assign flit_idx_err[gi] = flit_valid_op[gi] && (32'(flit_idx) >= 32'(max_vc_number));
      assign cred_idx_err[gi] = credit_valid_op[gi] && (32'(cred_idx) >= 32'(max_vc_number));

      for (gj = 0; gj < max_vc_number; gj++) begin : g_ovc
        localparam int idx = gi*max_vc_number + gj;

        ovc_state_e              state_q, state_d;
        logic [cred_width-1:0]   cred_q, cred_d;
        logic                    gnt_hit, flit_hit, cred_hit, ovc_err;

        assign gnt_hit  = gnt_op_ovc[idx];
        assign flit_hit = flit_valid_op[gi] && (flit_idx == vc_idx_width'(gj));
        assign cred_hit = credit_valid_op[gi] && (cred_idx == vc_idx_width'(gj));

        // Next credit count, next state and per-OVC violation detection.
        always_comb begin
          cred_d  = cred_q;
          state_d = state_q;
          ovc_err = 1'b0;

          // Flit and credit together cancel; alone they saturate at 0 / full.
          if (cred_hit && !flit_hit) begin
            if (cred_q != CRED_FULL) cred_d = cred_q + CRED_ONE;
          end else if (flit_hit && !cred_hit) begin
            if (cred_q != '0) cred_d = cred_q - CRED_ONE;
          end

          unique case (state_q)
            ST_IDLE:   if (gnt_hit) state_d = ST_ACTIVE;
            ST_ACTIVE: if (flit_hit && flit_tail_op[gi]) state_d = ST_DRAIN;
            // Release judged on the post-update count so the last credit frees it.
            ST_DRAIN:  if (cred_d == CRED_FULL) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
          endcase

          if (gnt_hit && state_q != ST_IDLE) ovc_err = 1'b1;
          if (flit_hit && (state_q != ST_ACTIVE || cred_q == '0)) ovc_err = 1'b1;
          if (cred_hit && cred_q == CRED_FULL) ovc_err = 1'b1;
        end

        // Per-OVC state and credit registers.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            state_q <= ST_IDLE;
            cred_q  <= CRED_FULL;
          end else begin
            state_q <= state_d;
            cred_q  <= cred_d;
          end
        end

        assign ovc_err_vec[idx]       = ovc_err;
        assign elig_op_ovc[idx]       = (state_q == ST_IDLE);
        assign cred_avail_op_ovc[idx] = (cred_q != '0);
      end
    end
  endgenerate

  // Sticky error accumulates every violation seen anywhere.
  always_comb begin
    error_d = error_q | (|ovc_err_vec) | (|flit_idx_err) | (|cred_idx_err);
  end

  // Error flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) error_q <= 1'b0;
    else        error_q <= error_d;
  end

  assign error = error_q;

endmodule

// File: tb/tb_ovc_state_tracker.sv
// Bench for ovc_state_tracker: a vector table for one packet lifetime,
// hand-written corner sequences, then model-checked random traffic.
module tb_ovc_state_tracker;
  localparam int P = 5;
  localparam int M = 20;
  localparam int B = 4;
  localparam int W = $clog2(M);
  localparam int N = P*M;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   gnt_op_ovc;
  logic [P-1:0]   flit_valid_op, flit_tail_op, credit_valid_op;
  logic [P*W-1:0] flit_ovc_op, credit_ovc_op;
  logic [N-1:0]   elig_op_ovc, cred_avail_op_ovc;
  logic           error;

  ovc_state_tracker #(.num_ports(P), .max_vc_number(M), .buffer_size(B)) dut (
    .clk(clk), .reset(reset),
    .gnt_op_ovc(gnt_op_ovc),
    .flit_valid_op(flit_valid_op), .flit_ovc_op(flit_ovc_op), .flit_tail_op(flit_tail_op),
    .credit_valid_op(credit_valid_op), .credit_ovc_op(credit_ovc_op),
    .elig_op_ovc(elig_op_ovc), .cred_avail_op_ovc(cred_avail_op_ovc), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = free, 1 = packet in flight, 2 = waiting for credits.
  int m_state[P][M];
  int m_cred[P][M];
  bit m_err;

  task automatic model_reset();
    for (int p = 0; p < P; p++)
      for (int v = 0; v < M; v++) begin
        m_state[p][v] = 0;
        m_cred[p][v]  = B;
      end
    m_err = 1'b0;
  endtask

  // Apply one clock's worth of events at the level of the protocol rules.
  task automatic model_step();
    bit g[P][M];
    bit f[P][M];
    bit t[P][M];
    bit c[P][M];
    for (int p = 0; p < P; p++)
      for (int v = 0; v < M; v++) begin
        g[p][v] = gnt_op_ovc[p*M+v];
        f[p][v] = 1'b0; t[p][v] = 1'b0; c[p][v] = 1'b0;
      end
    for (int p = 0; p < P; p++) begin
      if (flit_valid_op[p]) begin
        int i;
        i = int'(flit_ovc_op[p*W +: W]);
        if (i >= M) m_err = 1'b1;
        else begin f[p][i] = 1'b1; t[p][i] = flit_tail_op[p]; end
      end
      if (credit_valid_op[p]) begin
        int i;
        i = int'(credit_ovc_op[p*W +: W]);
        if (i >= M) m_err = 1'b1;
        else c[p][i] = 1'b1;
      end
    end
    for (int p = 0; p < P; p++)
      for (int v = 0; v < M; v++) begin
        int now, nxt;
        now = m_cred[p][v];
        nxt = now + int'(c[p][v]) - int'(f[p][v]);
        if (nxt < 0) nxt = 0;
        if (nxt > B) nxt = B;
        if (g[p][v] && m_state[p][v] != 0) m_err = 1'b1;
        if (f[p][v] && (m_state[p][v] != 1 || now == 0)) m_err = 1'b1;
        if (c[p][v] && now == B) m_err = 1'b1;
        if (m_state[p][v] == 0 && g[p][v]) m_state[p][v] = 1;
        else if (m_state[p][v] == 1 && f[p][v] && t[p][v]) m_state[p][v] = 2;
        else if (m_state[p][v] == 2 && nxt == B) m_state[p][v] = 0;
        m_cred[p][v] = nxt;
      end
  endtask

  function automatic logic [N-1:0] exp_elig();
    logic [N-1:0] r;
    r = '0;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < M; v++) r[p*M+v] = (m_state[p][v] == 0);
    return r;
  endfunction

  function automatic logic [N-1:0] exp_avail();
    logic [N-1:0] r;
    r = '0;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < M; v++) r[p*M+v] = (m_cred[p][v] != 0);
    return r;
  endfunction

  task automatic check_vec(string name, logic [N-1:0] act, logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    check_vec({tag, " elig"}, elig_op_ovc, exp_elig());
    check_vec({tag, " avail"}, cred_avail_op_ovc, exp_avail());
    check_bit({tag, " error"}, error, m_err);
  endtask

  task automatic idle_inputs();
    gnt_op_ovc = '0;
    flit_valid_op = '0; flit_tail_op = '0; flit_ovc_op = '0;
    credit_valid_op = '0; credit_ovc_op = '0;
  endtask

  task automatic set_gnt(int p, int v);
    gnt_op_ovc[p*M+v] = 1'b1;
  endtask

  task automatic set_flit(int p, int v, bit tail);
    flit_valid_op[p] = 1'b1;
    flit_tail_op[p]  = tail;
    flit_ovc_op[p*W +: W] = W'(v);
  endtask

  task automatic set_cred(int p, int v);
    credit_valid_op[p] = 1'b1;
    credit_ovc_op[p*W +: W] = W'(v);
  endtask

  // Clock edge with the current inputs, then compare one tick later.
  task automatic tick(string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
    $display("cycle %s: elig=%h avail=%h error=%b", tag, elig_op_ovc, cred_avail_op_ovc, error);
    idle_inputs();
  endtask

  // Asynchronous reset away from the clock edge; outputs must settle at once.
  task automatic apply_reset(string tag);
    idle_inputs();
    reset = 1'b0;
    #2;
    model_reset();
    check_vec({tag, " rst elig"}, elig_op_ovc, {N{1'b1}});
    check_vec({tag, " rst avail"}, cred_avail_op_ovc, {N{1'b1}});
    check_bit({tag, " rst error"}, error, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick({tag, " post-rst"});
  endtask

  typedef struct {
    bit gnt;
    bit flit;
    bit tail;
    bit cred;
    bit exp_elig;
    bit exp_avail;
    bit exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Packet lifetime on port 1, OVC 3: grant, 3 flits, 3 credits back.
    vecs[0] = '{1, 0, 0, 0, 0, 1, 0};
    vecs[1] = '{0, 1, 0, 0, 0, 1, 0};
    vecs[2] = '{0, 1, 0, 0, 0, 1, 0};
    vecs[3] = '{0, 1, 1, 0, 0, 1, 0};
    vecs[4] = '{0, 0, 0, 1, 0, 1, 0};
    vecs[5] = '{0, 0, 0, 1, 0, 1, 0};
    vecs[6] = '{0, 0, 0, 1, 1, 1, 0};

    idle_inputs();
    #1;
    apply_reset("init");

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].gnt)  set_gnt(1, 3);
      if (vecs[i].flit) set_flit(1, 3, vecs[i].tail);
      if (vecs[i].cred) set_cred(1, 3);
      tick($sformatf("vec%0d", i));
      check_bit($sformatf("vec%0d elig", i), elig_op_ovc[1*M+3], vecs[i].exp_elig);
      check_bit($sformatf("vec%0d avail", i), cred_avail_op_ovc[1*M+3], vecs[i].exp_avail);
      check_bit($sformatf("vec%0d error", i), error, vecs[i].exp_err);
    end

    // Flit and credit together at count 2 leave it at 2: two more flits empty it.
    set_gnt(2, 5); tick("c35 gnt");
    set_flit(2, 5, 0); tick("c35 f1");
    set_flit(2, 5, 0); tick("c35 f2");
    set_flit(2, 5, 0); set_cred(2, 5); tick("c35 both");
    check_bit("c35 both error", error, 1'b0);
    set_flit(2, 5, 0); tick("c35 f3");
    check_bit("c35 count1 avail", cred_avail_op_ovc[2*M+5], 1'b1);
    set_flit(2, 5, 0); tick("c35 f4");
    check_bit("c35 count0 avail", cred_avail_op_ovc[2*M+5], 1'b0);
    check_bit("c35 error", error, 1'b0);

    // Grant to an ACTIVE OVC is ignored and the error sticks.
    apply_reset("c36");
    set_gnt(0, 0); tick("c36 gnt");
    set_gnt(0, 0); tick("c36 regnt");
    check_bit("c36 error", error, 1'b1);
    check_bit("c36 elig", elig_op_ovc[0], 1'b0);
    set_flit(0, 0, 1); tick("c36 tail");
    for (int i = 0; i < 6; i++) begin
      if (i >= 4) set_cred(0, 0);
      tick("c36 hold");
    end
    check_bit("c36 sticky", error, 1'b1);
    check_bit("c36 released", elig_op_ovc[0], 1'b1);

    // Exhaust credits, then an extra flit errors without wrapping the counter.
    apply_reset("c34");
    set_gnt(1, 3); tick("c34 gnt");
    for (int i = 0; i < 4; i++) begin
      set_flit(1, 3, 0); tick("c34 flit");
    end
    check_bit("c34 avail empty", cred_avail_op_ovc[1*M+3], 1'b0);
    check_bit("c34 no error", error, 1'b0);
    set_flit(1, 3, 0); tick("c34 extra");
    check_bit("c34 error", error, 1'b1);
    check_bit("c34 held 0", cred_avail_op_ovc[1*M+3], 1'b0);
    set_cred(1, 3); tick("c34 cred");
    check_bit("c34 count1", cred_avail_op_ovc[1*M+3], 1'b1);

    // Out-of-range index is an error and touches no OVC.
    apply_reset("oor");
    set_flit(0, 20, 1); set_cred(4, 31); tick("oor");
    check_bit("oor error", error, 1'b1);
    check_vec("oor elig", elig_op_ovc, {N{1'b1}});

    // Reset during DRAIN with one credit left (and error raised).
    apply_reset("c37");
    set_gnt(3, 7); tick("c37 gnt");
    set_flit(3, 7, 0); tick("c37 f1");
    set_flit(3, 7, 0); tick("c37 f2");
    set_flit(3, 7, 1); tick("c37 tail");
    set_gnt(3, 7); tick("c37 bad gnt");
    check_bit("c37 drain elig", elig_op_ovc[3*M+7], 1'b0);
    apply_reset("c37");

    // Random traffic, mostly legal; later rounds inject violations.
    for (int r = 0; r < 4; r++) begin
      apply_reset($sformatf("rnd%0d", r));
      for (int cyc = 0; cyc < 150; cyc++) begin
        for (int p = 0; p < P; p++) begin
          bit inject;
          inject = (r > 0) && ($urandom_range(0, 99) < 3);
          for (int v = 0; v < M; v++)
            if ((m_state[p][v] == 0 || inject) && $urandom_range(0, 99) < 6) set_gnt(p, v);
          if ($urandom_range(0, 99) < 60) begin
            if (inject) set_flit(p, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            else
              for (int k = 0; k < 8; k++) begin
                int v;
                v = int'($urandom_range(0, M-1));
                if (!flit_valid_op[p] && m_state[p][v] == 1 && m_cred[p][v] > 0)
                  set_flit(p, v, $urandom_range(0, 99) < 35);
              end
          end
          if ($urandom_range(0, 99) < 60) begin
            if (inject) set_cred(p, int'($urandom_range(0, 31)));
            else
              for (int k = 0; k < 8; k++) begin
                int v;
                v = int'($urandom_range(0, M-1));
                if (!credit_valid_op[p] && m_cred[p][v] < B) set_cred(p, v);
              end
          end
        end
        tick($sformatf("rnd%0d.%0d", r, cyc));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
